seg7_mux_param: RTL and testbench
=================================

SEG7_MUX_PARAM -- requirements
Module: seg7_mux_param

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_CYCLES, default 50000, clk_50MHz cycles per digit slot (1 ms); legal >= 16.
REQ-003 SHALL have parameter BLANK_LZ, default 1, 1 = leading-zero blanking enabled.
REQ-004 SHALL have port clk_50MHz  input  1  system clock, rising edge.
REQ-005 SHALL have port reset_button  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port bcd  input  4*NUM_DIGITS  packed BCD; bcd[3:0] = digit 0 (ones).
REQ-007 SHALL have port dp_mask  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-008 SHALL have port brightness  input  4  duty level 0..15.
REQ-009 SHALL have port seg  output  8  registered segment drive, active-low, bit7..bit1 = a..g, bit0 = dp.
REQ-010 SHALL have port digit  output  NUM_DIGITS  registered one-hot digit enable, active-high.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at each frame start.

Function
REQ-012 SHALL run slot timer 0..REFRESH_CYCLES-1, width $clog2(REFRESH_CYCLES); wraps to 0 at terminal count.
REQ-013 SHALL advance digit select sel on timer terminal count; sel wraps NUM_DIGITS-1 -> 0.
REQ-014 SHALL capture bcd and dp_mask into a snapshot at every frame start (sel wrap to 0, or first edge after reset release); display SHALL use only the snapshot, so no tearing within a frame.
REQ-015 SHALL assert frame_tick for exactly the cycle in which the snapshot is loaded.
REQ-016 SHALL decode digit codes: 0=0000001x, 1=1001111x, 2=0010010x, 3=0000110x, 4=1001100x, 5=0100100x, 6=0100000x, 7=0001111x, 8=0000000x, 9=0000100x (bits 7..1 shown, x = dp).
REQ-017 SHALL display codes 10..15 as dash (g only, seg[7:1]=1111110).
REQ-018 SHALL, with BLANK_LZ=1, blank (seg[7:1]=1111111) every zero digit above the most significant nonzero digit; digit 0 is never blanked.
REQ-019 SHALL drive seg[0]=0 iff snapshot dp bit of the selected digit is 1, including on blanked digits.
REQ-020 SHALL update seg and digit registers one cycle after sel/timer change (fixed latency 1).
REQ-021 SHALL drive digit[sel]=1 and all other bits 0 while the slot is enabled (see REQ-025).

Reset
REQ-022 SHALL, while reset_button=1, hold timer=0, sel=0, snapshot=0, seg=8'hFF, digit=0, frame_tick=0.
REQ-023 SHALL load the snapshot and pulse frame_tick on the first rising edge after reset_button falls.
REQ-024 SHALL, on reset mid-frame, abandon the frame immediately; no partial slot is resumed.

Configuration
REQ-025 SHALL, with macro SEG7_PWM_EN defined, enable digit output only while timer < (brightness+1)*(REFRESH_CYCLES/16), else digit=0 and seg=8'hFF; brightness sampled at each slot start.
REQ-026 SHALL, with SEG7_PWM_EN undefined, ignore brightness and enable the digit for the full slot.

Verification
REQ-027 SHALL cover: NUM_DIGITS=4, REFRESH_CYCLES=16, bcd=16'h1234, dp_mask=0 -> digit sequence 0001,0010,0100,1000 every 16 cycles with seg 10011001, 00001101, 00100101, 10011111 (4,3,2,1 order by digit 0..3).
REQ-028 SHALL cover: bcd=16'h0070, BLANK_LZ=1 -> digits 3 and 2 seg=8'hFF, digit 1 seg=00011111, digit 0 seg=00000011.
REQ-029 SHALL cover: bcd changed from 16'h1111 to 16'h2222 mid-frame -> remainder of frame shows 1; next frame after frame_tick shows 2.
REQ-030 SHALL cover: bcd[3:0]=4'hB, dp_mask=4'b0001 -> digit 0 seg=11111100.
REQ-031 SHALL cover: SEG7_PWM_EN defined, REFRESH_CYCLES=32, brightness=3 -> digit high 8 of every 32 cycles; brightness=15 -> high all 32.
REQ-032 SHALL cover: reset_button pulsed at timer=7, sel=2 -> seg=8'hFF, digit=0 asynchronously; after release, frame_tick on first edge, sel=0.

Source files
------------

// File: rtl/seg7_mux_param.sv
`default_nettype none
// ============================================================================
// Module   : seg7_mux_param
// Purpose  : Time-multiplexed 7-segment driver with frame snapshot, leading-
//            zero blanking and optional PWM dimming (macro SEG7_PWM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_mux_param #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLANK_LZ       = 1
) (
    input  logic                    clk_50MHz,
    input  logic                    reset_button,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [3:0]              brightness,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame_tick
);
    localparam int c_TW = $clog2(REFRESH_CYCLES);
    localparam int c_SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_TW-1:0] c_TC   = c_TW'(REFRESH_CYCLES - 1);
    localparam logic [c_SW-1:0] c_LAST = c_SW'(NUM_DIGITS - 1);

    logic [c_TW-1:0]         r_timer;
    logic [c_SW-1:0]         r_sel;
    logic                    r_first;
    logic [4*NUM_DIGITS-1:0] r_snap_bcd;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_digit;
    logic                    r_frame_tick;

    logic                    w_tc;
    logic                    w_load;
    logic                    w_en;
    logic [3:0]              w_code;
    logic                    w_dp;
    logic                    w_upper_nz;
    logic                    w_blank;
    logic [6:0]              w_glyph;
    logic [7:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_digit_next;

    assign w_tc   = (r_timer == c_TC);
    // r_first forces a snapshot on the very first edge after reset release
    assign w_load = r_first || (w_tc && (r_sel == c_LAST));

    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            r_timer      <= '0;
            r_sel        <= '0;
            r_first      <= 1'b1;
            r_snap_bcd   <= '0;
            r_snap_dp    <= '0;
            r_seg        <= 8'hFF;
            r_digit      <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_first      <= 1'b0;
            r_timer      <= w_tc ? '0 : r_timer + 1'b1;
            if (w_tc) begin
                r_sel <= (r_sel == c_LAST) ? '0 : r_sel + 1'b1;
            end
            if (w_load) begin
                r_snap_bcd <= bcd;
                r_snap_dp  <= dp_mask;
            end
            r_frame_tick <= w_load;
            r_seg        <= w_seg_next;
            r_digit      <= w_digit_next;
        end
    end

`ifdef SEG7_PWM_EN
    localparam int c_STEP = REFRESH_CYCLES / 16;

    logic [3:0]    r_bright;
    logic [c_TW:0] w_on_limit;

    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            r_bright <= 4'd0;
        end else if (w_tc || r_first) begin
            r_bright <= brightness;
        end
    end

    assign w_on_limit = (c_TW+1)'((32'(r_bright) + 32'd1) * 32'(c_STEP));
    assign w_en       = ({1'b0, r_timer} < w_on_limit);
`else
    logic w_unused_brightness;
    assign w_unused_brightness = ^brightness;
    assign w_en                = 1'b1;
`endif

    // Blank a non-ones digit when it and everything above it are zero
    always_comb begin
        w_code     = 4'd0;
        w_dp       = 1'b0;
        w_upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c_SW'(i) == r_sel) begin
                w_code = r_snap_bcd[4*i +: 4];
                w_dp   = r_snap_dp[i];
            end
            if ((c_SW'(i) >= r_sel) && (r_snap_bcd[4*i +: 4] != 4'd0)) begin
                w_upper_nz = 1'b1;
            end
        end
        w_blank = (BLANK_LZ != 0) && (r_sel != '0) && !w_upper_nz;
    end

    always_comb begin
        w_glyph = 7'b1111110;
        case (w_code)
            4'd0:    w_glyph = 7'b0000001;
            4'd1:    w_glyph = 7'b1001111;
            4'd2:    w_glyph = 7'b0010010;
            4'd3:    w_glyph = 7'b0000110;
            4'd4:    w_glyph = 7'b1001100;
            4'd5:    w_glyph = 7'b0100100;
            4'd6:    w_glyph = 7'b0100000;
            4'd7:    w_glyph = 7'b0001111;
            4'd8:    w_glyph = 7'b0000000;
            4'd9:    w_glyph = 7'b0000100;
            default: w_glyph = 7'b1111110;
        endcase
    end

    always_comb begin
        w_seg_next   = 8'hFF;
        w_digit_next = '0;
        if (w_en) begin
            w_seg_next = {(w_blank ? 7'h7F : w_glyph), ~w_dp};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                w_digit_next[i] = (c_SW'(i) == r_sel);
            end
        end
    end

    assign seg        = r_seg;
    assign digit      = r_digit;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_mux_param
// Purpose  : Scoreboard bench for seg7_mux_param against a slot/frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_mux_param;
    localparam int N = 4;
`ifdef SEG7_PWM_EN
    localparam int R = 32;
`else
    localparam int R = 16;
`endif

    logic        clk_50MHz    = 1'b0;
    logic        reset_button = 1'b1;
    logic [15:0] bcd          = 16'h0000;
    logic [3:0]  dp_mask      = 4'h0;
    logic [3:0]  brightness   = 4'hF;
    logic [7:0]  seg;
    logic [3:0]  digit;
    logic        frame_tick;

    seg7_mux_param #(
        .NUM_DIGITS     (N),
        .REFRESH_CYCLES (R),
        .BLANK_LZ       (1)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset_button (reset_button),
        .bcd          (bcd),
        .dp_mask      (dp_mask),
        .brightness   (brightness),
        .seg          (seg),
        .digit        (digit),
        .frame_tick   (frame_tick)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] digit;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: k counts clock edges since reset release
    int          k        = 0;
    logic [15:0] m_bcd    = 16'h0000;
    logic [3:0]  m_dp     = 4'h0;
    int          m_bright = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    // Outputs after edge k reflect the slot position held after edge k-1
    task automatic step_model();
        exp_t       e;
        int         p, sel, tmr, msd;
        logic [3:0] nib;
        logic       on;
        k++;
        p   = k - 1;
        sel = (p / R) % N;
        tmr = p % R;
        nib = m_bcd[4*sel +: 4];
        msd = -1;
        for (int j = 0; j < N; j++) if (m_bcd[4*j +: 4] != 4'd0) msd = j;
        on = 1'b1;
`ifdef SEG7_PWM_EN
        on = (tmr < (m_bright + 1) * (R / 16));
`endif
        if (!on) begin
            e.seg   = 8'hFF;
            e.digit = 4'h0;
        end else begin
            e.digit    = 4'(1 << sel);
            e.seg[7:1] = (sel != 0 && sel > msd) ? 7'h7F : glyph(nib);
            e.seg[0]   = ~m_dp[sel];
        end
        e.tick = (k == 1) || (k % (R * N) == 0);
        if (e.tick) begin
            m_bcd = bcd;
            m_dp  = dp_mask;
        end
        if (k == 1 || k % R == 0) m_bright = int'(brightness);
        q.push_back(e);
    endtask

    task automatic push_reset();
        exp_t e;
        k        = 0;
        m_bcd    = 16'h0000;
        m_dp     = 4'h0;
        m_bright = 0;
        e.seg    = 8'hFF;
        e.digit  = 4'h0;
        e.tick   = 1'b0;
        q.push_back(e);
    endtask

    task automatic drive(input logic [15:0] b, input logic [3:0] d, input logic [3:0] br, input logic rst);
        @(negedge clk_50MHz);
        bcd          = b;
        dp_mask      = d;
        brightness   = br;
        reset_button = rst;
        if (rst) push_reset();
        else     step_model();
    endtask

    task automatic run(input logic [15:0] b, input logic [3:0] d, input logic [3:0] br, input int n);
        for (int i = 0; i < n; i++) drive(b, d, br, 1'b0);
    endtask

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] v;
        for (int j = 0; j < 4; j++)
            v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    // Monitor: compares every registered output sample against the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_50MHz);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("seg", 32'(seg), 32'(e.seg));
                chk("digit", 32'(digit), 32'(e.digit));
                chk("frame_tick", 32'(frame_tick), 32'(e.tick));
            end
        end
    end

    initial begin
        logic [15:0] rb;
        logic [3:0]  rd;
        for (int i = 0; i < 3; i++) drive(16'h0000, 4'h0, 4'hF, 1'b1);

        run(16'h1234, 4'b0000, 4'd3,  2 * R * N);
        run(16'h0070, 4'b0000, 4'd15, 2 * R * N);
        run(16'h000B, 4'b0001, 4'd7,  2 * R * N);
        run(16'h0000, 4'b1010, 4'd0,  2 * R * N);
        run(16'h8F05, 4'b0110, 4'd15, 2 * R * N);
        run(16'h1111, 4'b0000, 4'd15, R * N + R + 3);
        run(16'h2222, 4'b0000, 4'd15, 2 * R * N);

        // Reset mid-frame at timer=7, sel=2
        drive(16'h1234, 4'h0, 4'hF, 1'b1);
        run(16'h1234, 4'b0000, 4'd15, 2 * R + 7);
        @(negedge clk_50MHz);
        reset_button = 1'b1;
        #1;
        chk("async_seg", 32'(seg), 32'h0000_00FF);
        chk("async_digit", 32'(digit), 32'h0);
        push_reset();
        drive(16'h4321, 4'h0, 4'hF, 1'b1);
        run(16'h4321, 4'b1000, 4'd15, 2 * R * N);

        rb = rnd_bcd();
        rd = 4'($urandom_range(0, 15));
        for (int i = 0; i < 40 * R; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rb = rnd_bcd();
                rd = 4'($urandom_range(0, 15));
            end
            drive(rb, rd, 4'($urandom_range(0, 15)), 1'b0);
        end

        @(posedge clk_50MHz);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
